// File: rtl/tile_map_renderer_pkg.sv
// Shared constants, colour palette and FSM state type for the tile map renderer.
package tile_map_renderer_pkg;

  localparam int unsigned SCREEN_W    = 320;
  localparam int unsigned SCREEN_H    = 240;
  localparam int unsigned SQUARE_SIZE = 4;
  localparam int unsigned COLOUR_W    = 3;

  typedef logic [COLOUR_W-1:0] colour_t;

  localparam colour_t COLOUR_BLACK   = 3'b000;
  localparam colour_t COLOUR_BLUE    = 3'b001;
  localparam colour_t COLOUR_GREEN   = 3'b010;
  localparam colour_t COLOUR_CYAN    = 3'b011;
  localparam colour_t COLOUR_RED     = 3'b100;
  localparam colour_t COLOUR_MAGENTA = 3'b101;
  localparam colour_t COLOUR_YELLOW  = 3'b110;
  localparam colour_t COLOUR_WHITE   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MEM_WAIT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_FINISH
  } state_t;

  // Counter/address width that stays at least one bit for a 1-entry range.
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_map_renderer_if.sv
// Bundle of game-logic, map RAM and square drawer signals seen by the renderer.
interface tile_map_renderer_if
  import tile_map_renderer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic              render_start;
  logic              render_busy;
  logic              render_done;
  logic [ADDR_W-1:0] map_addr;
  colour_t           map_data;
  logic              sq_start;
  logic              sq_done;
  logic [8:0]        sq_x;
  logic [7:0]        sq_y;
  colour_t           sq_colour;

  modport master (
    input  render_start, map_data, sq_done,
    output render_busy, render_done, map_addr, sq_start, sq_x, sq_y, sq_colour
  );

  modport slave (
    output render_start, map_data, sq_done,
    input  render_busy, render_done, map_addr, sq_start, sq_x, sq_y, sq_colour
  );

endinterface

// File: rtl/tile_map_renderer_cursor.sv
// Row/column cursor over the tile grid: clear, raster advance and last-cell flag.
module tile_cursor
  import tile_map_renderer_pkg::*;
#(
  parameter int unsigned GRID_W = 16,
  parameter int unsigned GRID_H = 16,
  localparam int unsigned COL_W = width_for(GRID_W),
  localparam int unsigned ROW_W = width_for(GRID_H)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             last_col;
  logic             last_row;

  assign last_col = (col_q == COL_W'(GRID_W - 1));
  assign last_row = (row_q == ROW_W'(GRID_H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i && !(last_col && last_row)) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = last_col && last_row;

endmodule

// File: rtl/tile_map_renderer.sv
// Walks the tile map in raster order, fetching each cell colour and handing
// one 4x4 square per cell to the square drawer via a start/done handshake.
module tile_map_renderer
  import tile_map_renderer_pkg::*;
#(
  parameter int unsigned GRID_W      = 16,
  parameter int unsigned GRID_H      = 16,
  parameter int unsigned X_ORIGIN    = 0,
  parameter int unsigned Y_ORIGIN    = 0,
  parameter bit          SKIP_EN     = 1'b0,
  parameter colour_t     SKIP_COLOUR = COLOUR_BLACK
) (
  input  logic                 clock,
  input  logic                 resetn,
  tile_map_renderer_if.master  bus
);

  localparam int unsigned ADDR_W = width_for(GRID_W * GRID_H);
  localparam int unsigned COL_W  = width_for(GRID_W);
  localparam int unsigned ROW_W  = width_for(GRID_H);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  colour_t           colour_q, colour_d;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              last_cell;
  logic              cursor_clear;
  logic              cursor_advance;

  assign cursor_clear   = (state_q == ST_IDLE) && bus.render_start;
  assign cursor_advance = (state_q == ST_ADVANCE);

  tile_cursor #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_cursor (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .clear_i   (cursor_clear),
    .advance_i (cursor_advance),
    .col_o     (col),
    .row_o     (row),
    .last_o    (last_cell)
  );

  // The address register is loaded one state ahead (on start / in ADVANCE) so
  // it is already stable during FETCH; in raster order row*GRID_W+col is just
  // the previous address plus one.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.render_start) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        colour_d = bus.map_data;
        x_d      = (9'(col) << 2) + 9'(X_ORIGIN);
        y_d      = (8'(row) << 2) + 8'(Y_ORIGIN);
        if (SKIP_EN && (bus.map_data == SKIP_COLOUR)) state_d = ST_ADVANCE;
        else                                          state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.sq_done) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (last_cell) begin
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign bus.map_addr    = addr_q;
  assign bus.sq_x        = x_q;
  assign bus.sq_y        = y_q;
  assign bus.sq_colour   = colour_q;
  assign bus.sq_start    = (state_q == ST_ISSUE);
  assign bus.render_busy = (state_q != ST_IDLE);
  assign bus.render_done = (state_q == ST_FINISH);

endmodule
